// File: rtl/pwm_generator_pkg.sv
// Shared definitions for the PWM output stage: FSM encodings, default width
// and the output level helper.
package pwm_generator_pkg;

  localparam int PWM_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    PWM_IDLE  = 2'd0,
    PWM_RUN   = 2'd1,
    PWM_DRAIN = 2'd2
  } pwm_state_e;

  // Output pin level for a given activity and polarity (pol=1 means active-low).
  function automatic logic pwm_level(input logic active, input logic pol);
    return active ? ~pol : pol;
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Staging/shadow register pair for period, duty and polarity. A load lands in
// staging; staging moves to shadow only when the top grants apply_ok.
module pwm_shadow_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             apply_ok,
  input  logic [WIDTH-1:0] new_period,
  input  logic [WIDTH-1:0] new_duty,
  input  logic             new_pol,
  output logic             apply,
  output logic [WIDTH-1:0] cur_period,
  output logic [WIDTH-1:0] eff_period,
  output logic [WIDTH-1:0] eff_duty,
  output logic             eff_pol
);

  logic [WIDTH-1:0] stg_period;
  logic [WIDTH-1:0] stg_duty;
  logic             stg_pol;
  logic [WIDTH-1:0] shd_period;
  logic [WIDTH-1:0] shd_duty;
  logic             shd_pol;
  logic             pending;

  // Only a load registered before this cycle can be applied now; a load in the
  // apply cycle itself refills staging and keeps pending for the next window.
  assign apply = pending & apply_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_period <= '0;
      stg_duty   <= '0;
      stg_pol    <= 1'b0;
      shd_period <= '0;
      shd_duty   <= '0;
      shd_pol    <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_period <= new_period;
        stg_duty   <= new_duty;
        stg_pol    <= new_pol;
      end
      if (apply) begin
        shd_period <= stg_period;
        shd_duty   <= stg_duty;
        shd_pol    <= stg_pol;
      end
      if (load)
        pending <= 1'b1;
      else if (apply)
        pending <= 1'b0;
    end
  end

  // Values that will be in force next cycle, so output flops see fresh settings at cnt=0.
  assign cur_period = shd_period;
  assign eff_period = apply ? stg_period : shd_period;
  assign eff_duty   = apply ? stg_duty   : shd_duty;
  assign eff_pol    = apply ? stg_pol    : shd_pol;

endmodule

// File: rtl/pwm_generator.sv
// PWM output stage: run/drain FSM, period counter and registered outputs.
// New settings only take effect at a period boundary so the pin never glitches.
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_polarity,
  output logic             o_pwm,
  output logic             o_period_end,
  output logic             o_load_ack,
  output logic             o_busy
);

  pwm_state_e       state;
  pwm_state_e       state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cur_period;
  logic [WIDTH-1:0] eff_period;
  logic [WIDTH-1:0] eff_duty;
  logic             eff_pol;
  logic             apply;
  logic             apply_ok;
  logic             running;
  logic             boundary;
  logic             pwm_nxt;
  logic             pe_nxt;

  assign running  = (state != PWM_IDLE);
  assign boundary = running && (cur_period != '0) && (cnt == cur_period - WIDTH'(1));
  assign apply_ok = !running || boundary;

  pwm_shadow_reg #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (i_load),
    .apply_ok   (apply_ok),
    .new_period (i_period),
    .new_duty   (i_duty),
    .new_pol    (i_polarity),
    .apply      (apply),
    .cur_period (cur_period),
    .eff_period (eff_period),
    .eff_duty   (eff_duty),
    .eff_pol    (eff_pol)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      PWM_IDLE: begin
        if (i_en && (eff_period != '0))
          state_nxt = PWM_RUN;
      end
      PWM_RUN, PWM_DRAIN: begin
        if (boundary && (eff_period == '0))
          state_nxt = PWM_IDLE;
        else if (i_en)
          state_nxt = PWM_RUN;
        else if (boundary)
          state_nxt = PWM_IDLE;
        else
          state_nxt = PWM_DRAIN;
      end
      default: state_nxt = PWM_IDLE;
    endcase
  end

  // Outputs are computed from the next count so the flops line up with cnt.
  always_comb begin
    cnt_nxt = '0;
    pwm_nxt = eff_pol;
    pe_nxt  = 1'b0;
    if (state_nxt != PWM_IDLE) begin
      if (running && !boundary)
        cnt_nxt = cnt + WIDTH'(1);
      pwm_nxt = pwm_level(cnt_nxt < eff_duty, eff_pol);
      pe_nxt  = (cnt_nxt == eff_period - WIDTH'(1));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= PWM_IDLE;
      cnt          <= '0;
      o_pwm        <= 1'b0;
      o_period_end <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      o_pwm        <= pwm_nxt;
      o_period_end <= pe_nxt;
    end
  end

  assign o_busy     = running;
  assign o_load_ack = apply;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: table of duty/polarity settings plus hand-written
// sequences for drain, multi-load, zero period and mid-period reset.
module tb_pwm_generator;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_load = 1'b0;
  logic        i_polarity = 1'b0;
  logic [15:0] i_period = '0;
  logic [15:0] i_duty = '0;
  logic        o_pwm;
  logic        o_period_end;
  logic        o_load_ack;
  logic        o_busy;

  int          n_checks = 0;
  int          n_pass = 0;
  int          ecnt = 0;
  logic [15:0] cur_d = '0;
  logic        cur_pol = 1'b0;

  typedef struct {
    string      nm;
    logic [3:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [15:0] d;
    logic        pol;
    logic        exp_first;
    int          exp_active;
  } vec_t;
  vec_t tbl[9];

  pwm_generator #(.WIDTH(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_load       (i_load),
    .i_period     (i_period),
    .i_duty       (i_duty),
    .i_polarity   (i_polarity),
    .o_pwm        (o_pwm),
    .o_period_end (o_period_end),
    .o_load_ack   (o_load_ack),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic void chk4(string nm, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: pwm/pe/ack/busy got %b expected %b", nm, act, exp);
  endfunction

  function automatic void chk_int(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // Scoreboard consumer: outputs after each edge against the oldest expectation.
  always @(posedge i_clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk4(mon_e.nm, {o_pwm, o_period_end, o_load_ack, o_busy}, mon_e.exp);
    end
  end

  task automatic drive(input logic en, input logic ld, input logic [15:0] p,
                       input logic [15:0] d, input logic pol,
                       input logic [3:0] exp, input string nm);
    exp_t e;
    i_en       = en;
    i_load     = ld;
    i_period   = p;
    i_duty     = d;
    i_polarity = pol;
    e.nm  = nm;
    e.exp = exp;
    sb.push_back(e);
    @(posedge i_clk);
    #2;
  endtask

  // One running cycle with P=10; expected level from the settings in force at the next count.
  task automatic tick(input logic en, input logic ld, input logic [15:0] ld_d,
                      input logic ld_pol, input logic ack, input string nm);
    int   nc;
    logic lvl;
    nc  = (ecnt == 9) ? 0 : ecnt + 1;
    lvl = (nc < int'(cur_d)) ? ~cur_pol : cur_pol;
    drive(en, ld, 16'd10, ld_d, ld_pol, {lvl, (nc == 9), ack, 1'b1}, nm);
    ecnt = nc;
  endtask

  // Load new duty/polarity at cnt=4 of a running P=10 stream, ride out to the boundary.
  task automatic reprogram(input logic [15:0] d, input logic pol, input string nm);
    while (ecnt != 4) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, {nm, "_pre"});
    tick(1'b1, 1'b1, d, pol, 1'b0, {nm, "_load"});
    while (ecnt != 9) tick(1'b1, 1'b0, 16'd0, 1'b0, (ecnt == 8), {nm, "_wait"});
    cur_d   = d;
    cur_pol = pol;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    tbl[0] = '{16'd7,  1'b0, 1'b1, 7};
    tbl[1] = '{16'd0,  1'b0, 1'b0, 0};
    tbl[2] = '{16'd12, 1'b0, 1'b1, 10};
    tbl[3] = '{16'd0,  1'b1, 1'b1, 0};
    tbl[4] = '{16'd12, 1'b1, 1'b0, 10};
    tbl[5] = '{16'd10, 1'b0, 1'b1, 10};
    tbl[6] = '{16'd9,  1'b1, 1'b0, 9};
    tbl[7] = '{16'd1,  1'b0, 1'b1, 1};
    tbl[8] = '{16'd3,  1'b0, 1'b1, 3};

    #12;
    chk4("reset", {o_pwm, o_period_end, o_load_ack, o_busy}, 4'b0000);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Load in IDLE: ack one cycle later, then 3-of-10 stream.
    drive(1'b0, 1'b1, 16'd10, 16'd3, 1'b0, 4'b0010, "t1_ack");
    drive(1'b1, 1'b0, 16'd10, 16'd3, 1'b0, 4'b1001, "t1_start");
    cur_d = 16'd3; cur_pol = 1'b0; ecnt = 0;
    repeat (19) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t1_run");

    // Duty/polarity table, each applied at a boundary and measured over one period.
    for (int i = 0; i < 9; i++) begin
      reprogram(tbl[i].d, tbl[i].pol, $sformatf("tbl%0d", i));
      act = 0;
      for (int k = 0; k < 10; k++) begin
        tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, $sformatf("tbl%0d_run", i));
        if (k == 0) chk4($sformatf("tbl%0d_first", i), {3'b000, o_pwm}, {3'b000, tbl[i].exp_first});
        if (o_pwm !== tbl[i].pol) act++;
      end
      chk_int($sformatf("tbl%0d_active", i), act, tbl[i].exp_active);
    end

    // Stop at cnt=2 drains to the boundary; re-raise in drain keeps phase.
    repeat (3) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t4_run");
    while (ecnt != 9) tick(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "t4_drain");
    drive(1'b0, 1'b0, 16'd10, 16'd0, 1'b0, 4'b0000, "t4_idle");
    drive(1'b0, 1'b0, 16'd10, 16'd0, 1'b0, 4'b0000, "t4_idle2");
    drive(1'b1, 1'b0, 16'd10, 16'd0, 1'b0, 4'b1001, "t4_restart");
    ecnt = 0;
    repeat (2) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t4_run2");
    repeat (3) tick(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "t4_drain2");
    while (ecnt != 9) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t4_resume");
    tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t4_wrap");
    while (ecnt != 9) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t4_after");

    // Loads at cnt=1 and cnt=5 collapse to one ack; a boundary-cycle load waits a period.
    for (int k = 0; k < 10; k++) begin
      if (ecnt == 1)      tick(1'b1, 1'b1, 16'd5, 1'b0, 1'b0, "t5_load1");
      else if (ecnt == 5) tick(1'b1, 1'b1, 16'd8, 1'b0, 1'b0, "t5_load2");
      else                tick(1'b1, 1'b0, 16'd0, 1'b0, (ecnt == 8), "t5_a");
    end
    cur_d = 16'd8;
    tick(1'b1, 1'b1, 16'd2, 1'b0, 1'b0, "t5_load3");
    while (ecnt != 9) tick(1'b1, 1'b0, 16'd0, 1'b0, (ecnt == 8), "t5_b");
    cur_d = 16'd2;
    repeat (10) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t5_c");

    // Zero period applied at a boundary: back to IDLE, pin at polarity level.
    while (ecnt != 4) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "p0_pre");
    drive(1'b1, 1'b1, 16'd0, 16'd3, 1'b1, 4'b0001, "p0_load");
    ecnt = 5;
    while (ecnt != 9) tick(1'b1, 1'b0, 16'd0, 1'b0, (ecnt == 8), "p0_wait");
    drive(1'b1, 1'b0, 16'd10, 16'd0, 1'b0, 4'b1000, "p0_idle");
    drive(1'b1, 1'b0, 16'd10, 16'd0, 1'b0, 4'b1000, "p0_stay");

    // Mid-period reset clears outputs at once and wipes the shadow settings.
    drive(1'b1, 1'b1, 16'd10, 16'd3, 1'b1, 4'b1010, "t6_ack");
    drive(1'b1, 1'b0, 16'd10, 16'd0, 1'b0, 4'b0001, "t6_start");
    cur_d = 16'd3; cur_pol = 1'b1; ecnt = 0;
    while (ecnt != 6) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t6_run");
    i_rst = 1'b1;
    #1;
    chk4("t6_rst_async", {o_pwm, o_period_end, o_load_ack, o_busy}, 4'b0000);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 16'd10, 16'd3, 1'b0, 4'b0000, "t6_stay_idle");
    drive(1'b1, 1'b1, 16'd10, 16'd3, 1'b0, 4'b0010, "t6_reload");
    drive(1'b1, 1'b0, 16'd10, 16'd0, 1'b0, 4'b1001, "t6_rerun");
    cur_d = 16'd3; cur_pol = 1'b0; ecnt = 0;
    repeat (12) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t6_run2");

    chk_int("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
